// File: rtl/instr_loader_pkg.sv
// Shared constants and FSM state encoding for the instruction memory loader.
// These constants are also used by the instruction memory.
package instr_loader_pkg;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 16;
    localparam int START_ADDR = 1;
    localparam int MAX_WORDS  = (1 << ADDR_W) - START_ADDR;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        CHK,
        DONE
    } state_t;

endpackage

// File: rtl/instr_mem_loader_byte_pair_assembler.sv
// Collects hi/lo payload bytes into one instruction word.
// Under LOADER_CHECKSUM_EN it also keeps a running XOR of the payload bytes.
module byte_pair_assembler
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
`ifdef LOADER_CHECKSUM_EN
    input  logic              i_clr,
    output logic [7:0]        o_xor,
`endif
    input  logic              i_hi_en,
    input  logic              i_lo_en,
    input  logic [7:0]        i_byte,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_valid
);

    logic [7:0]        r_hi;
    logic [DATA_W-1:0] r_word;
    logic              r_word_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi         <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= i_lo_en;
            if (i_hi_en) r_hi <= i_byte;
            // The word only changes on the edge that starts its write cycle
            if (i_lo_en) r_word <= {r_hi, i_byte};
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_xor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   r_xor <= '0;
        else if (i_clr)               r_xor <= '0;
        else if (i_hi_en || i_lo_en)  r_xor <= r_xor ^ i_byte;
    end

    assign o_xor = r_xor;
`endif

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction memory write port; holds the CPU while active.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            r_state, w_next;
    logic [7:0]        r_len_hi;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_busy, r_hold, r_done, r_err;
    logic              w_xfer, w_start, w_hi_en, w_lo_en, w_word_valid;
    logic [15:0]       w_len;
    logic [DATA_W-1:0] w_word;

    assign in_ready = r_state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK};
    assign w_xfer   = in_valid && in_ready;
    assign w_start  = (r_state == IDLE) && start;
    assign w_len    = {r_len_hi, in_data};
    assign w_hi_en  = (r_state == DATA_HI) && w_xfer;
    assign w_lo_en  = (r_state == DATA_LO) && w_xfer;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] w_xor;
    localparam state_t S_TAIL = CHK;
`else
    localparam state_t S_TAIL = DONE;
`endif

    byte_pair_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef LOADER_CHECKSUM_EN
        .i_clr        (w_start),
        .o_xor        (w_xor),
`endif
        .i_hi_en      (w_hi_en),
        .i_lo_en      (w_lo_en),
        .i_byte       (in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start)  w_next = LEN_HI;
            LEN_HI:  if (w_xfer) w_next = LEN_LO;
            LEN_LO: begin
                // Oversize frames end here without consuming any payload
                if (w_xfer) begin
                    if (w_len == 16'd0)                 w_next = S_TAIL;
                    else if (w_len > 16'(MAX_WORDS))    w_next = DONE;
                    else                                w_next = DATA_HI;
                end
            end
            DATA_HI: if (w_xfer) w_next = DATA_LO;
            DATA_LO: if (w_xfer) w_next = WRITE;
            WRITE: begin
                if (r_remaining == ADDR_W'(1)) w_next = S_TAIL;
                else                           w_next = DATA_HI;
            end
            CHK:     if (w_xfer) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_len_hi    <= '0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_wr_addr   <= '0;
            r_busy      <= 1'b0;
            r_hold      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_busy <= 1'b1;
                r_hold <= 1'b1;
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if ((r_state == LEN_HI) && w_xfer) r_len_hi <= in_data;
            if ((r_state == LEN_LO) && w_xfer) begin
                if (w_len > 16'(MAX_WORDS)) begin
                    r_err <= 1'b1;
                end else begin
                    r_addr      <= ADDR_W'(START_ADDR);
                    r_remaining <= w_len[ADDR_W-1:0];
                end
            end
            if (w_lo_en) r_wr_addr <= r_addr;
            if (r_state == WRITE) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - ADDR_W'(1);
            end
`ifdef LOADER_CHECKSUM_EN
            if ((r_state == CHK) && w_xfer && (in_data != w_xor)) r_err <= 1'b1;
`endif
            if (r_state == DONE) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
                r_hold <= 1'b0;
            end
        end
    end

    assign wr_en    = w_word_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = w_word;
    assign cpu_hold = r_hold;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes queued at stimulus time,
// a monitor pops and compares on every wr_en. Checksum tests run under LOADER_CHECKSUM_EN.
module tb_instr_mem_loader;
    import instr_loader_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready, wr_en, cpu_hold, busy, done, err;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    instr_mem_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    int          n_pass = 0;
    int          n_total = 0;
    int          wr_count = 0;
    wr_t         exp_q[$];
    logic [15:0] tx[$];

    task automatic check(input string name, input bit ok,
                         input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every write strobe is compared against the scoreboard
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && wr_en) begin
                check("in_ready_in_write", in_ready == 1'b0, 32'(in_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1'b0, 32'({wr_addr, wr_data}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("write", {wr_addr, wr_data} == e,
                          32'({wr_addr, wr_data}), 32'(e));
                end
                wr_count++;
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_state", busy && cpu_hold && !done && !err,
              32'({busy, cpu_hold, done, err}), 32'b1100);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit rdy = 1'b0;
        if (gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) break;
        end
        in_valid = 1'b0;
        if (!rdy) check("byte_accept_timeout", 1'b0, 32'(b), 32'd1);
    endtask

    task automatic send_frame(input int n, input bit gap);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++)
            exp_q.push_back(wr_t'{a: ADDR_W'(START_ADDR + i), d: tx[i]});
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        for (int i = 0; i < n; i++) begin
            send_byte(tx[i][15:8], gap);
            send_byte(tx[i][7:0], gap);
            x = x ^ tx[i][15:8] ^ tx[i][7:0];
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x, gap);
`endif
    endtask

    task automatic wait_done(input bit exp_err);
        bit got = 1'b0;
        bit hold_ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (!cpu_hold || !busy) hold_ok = 1'b0;
        end
        check("done", got, 32'(done), 32'd1);
        check("hold_until_done", hold_ok, 32'(hold_ok), 32'd1);
        check("err", err == exp_err, 32'(err), 32'(exp_err));
        check("released", !busy && !cpu_hold, 32'({busy, cpu_hold}), 32'd0);
        check("all_writes_seen", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int  c0;
        bit  stuck_ok;
        #23;
        check("reset_outputs",
              {in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err} == '0,
              32'({in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err}), 32'd0);
        #4 rst_n = 1'b1;

        // N=2, continuous valid
        tx = '{16'h1234, 16'hABCD};
        do_start();
        send_frame(2, 1'b0);
        wait_done(1'b0);

        // Same frame, valid toggling
        do_start();
        send_frame(2, 1'b1);
        wait_done(1'b0);

        // Empty frame
        do_start();
        send_frame(0, 1'b0);
        wait_done(1'b0);

        // Oversize length: rejected, next byte left unconsumed
        c0 = wr_count;
        do_start();
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        in_data  = 8'hEE;
        in_valid = 1'b1;
        stuck_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready) stuck_ok = 1'b0;
        end
        in_valid = 1'b0;
        check("oversize_not_ready", stuck_ok, 32'(stuck_ok), 32'd1);
        wait_done(1'b1);
        check("oversize_no_writes", wr_count == c0, 32'(wr_count - c0), 32'd0);

        // Maximum length: addresses 1..1023, no wrap
        tx.delete();
        for (int k = 1; k <= 1023; k++) tx.push_back(16'(k) ^ 16'hA500);
        c0 = wr_count;
        do_start();
        send_frame(1023, 1'b0);
        wait_done(1'b0);
        check("max_write_count", wr_count - c0 == 1023, 32'(wr_count - c0), 32'd1023);

        // Reset after first write of N=3
        c0 = wr_count;
        do_start();
        exp_q.push_back(wr_t'{a: ADDR_W'(START_ADDR), d: 16'h1111});
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h11, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (wr_count != c0) break;
        end
        check("first_write_before_reset", wr_count == c0 + 1, 32'(wr_count - c0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err} == '0,
              32'({in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err}), 32'd0);
        check("reset_queue_empty", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tx = '{16'h5A5A, 16'h0F0F};
        do_start();
        send_frame(2, 1'b0);
        wait_done(1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Explicit checksum frames: good (0x26) then bad (0x27)
        do_start();
        exp_q.push_back(wr_t'{a: ADDR_W'(1), d: 16'h1234});
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h26, 1'b0);
        wait_done(1'b0);

        do_start();
        exp_q.push_back(wr_t'{a: ADDR_W'(1), d: 16'h1234});
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h27, 1'b0);
        wait_done(1'b1);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
